// File: rtl/sync_clk_div_chk.sv
// Divided-clock checker: samples a divided clock in the i_clk_ref domain, checks period/high time
// against 2^k and reports lock and sticky lock-loss. Define SYNC_CLK_DIV_CHK_SYNC_EN for a 2-flop input synchronizer.
module sync_clk_div_chk #(
    parameter int unsigned MaxLog2   = 4,
    parameter int unsigned LockCount = 4
) (
    input  logic               i_clk_ref,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_div_clk,
    input  logic [2:0]         i_div_log2,
    input  logic               i_err_clr,
    output logic               o_locked,
    output logic               o_err,
    output logic [MaxLog2+1:0] o_period
);

    localparam int unsigned W  = MaxLog2 + 2;
    localparam int unsigned GW = $clog2(LockCount + 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_t;

    state_t         state;
    logic           div_in;
    logic           d1, d2;
    logic [2:0]     k_q;
    logic [W-1:0]   per_cnt, hi_cnt;
    logic [W-1:0]   exp_per, exp_hi;
    logic [GW-1:0]  good_cnt;
    logic           rise, legal, cfg_chg, go_idle;
    logic           good, bad_rise, stuck, err_set;

`ifdef SYNC_CLK_DIV_CHK_SYNC_EN
    logic s1, s2;

    always_ff @(posedge i_clk_ref or posedge i_rst) begin
        if (i_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= i_div_clk;
            s2 <= s1;
        end
    end

    assign div_in = s2;
`else
    assign div_in = i_div_clk;
`endif

    always_ff @(posedge i_clk_ref or posedge i_rst) begin
        if (i_rst) begin
            d1  <= 1'b0;
            d2  <= 1'b0;
            k_q <= '0;
        end else begin
            d1  <= div_in;
            d2  <= d1;
            k_q <= i_div_log2;
        end
    end

    always_comb begin
        rise     = d1 & ~d2;
        legal    = (k_q != 3'd0) && (32'(k_q) <= MaxLog2);
        cfg_chg  = (i_div_log2 != k_q);
        go_idle  = !i_en || !legal;
        exp_per  = W'(1) << k_q;
        exp_hi   = W'(1) << (k_q - 3'd1);
        good     = rise && (per_cnt == exp_per) && (hi_cnt == exp_hi);
        bad_rise = rise && !good;
        // A missing edge once the full period has elapsed covers both stuck and slow clocks.
        stuck    = !rise && (per_cnt >= exp_per);
        err_set  = (state == LOCKED) && !go_idle && !cfg_chg && (bad_rise || stuck);
    end

    always_ff @(posedge i_clk_ref or posedge i_rst) begin
        if (i_rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (go_idle || state == IDLE) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= W'(1);
            hi_cnt  <= W'(1);
        end else begin
            if (per_cnt != '1) per_cnt <= per_cnt + W'(1);
            if (d1)            hi_cnt  <= hi_cnt + W'(1);
        end
    end

    always_ff @(posedge i_clk_ref or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            good_cnt <= '0;
            o_locked <= 1'b0;
            o_err    <= 1'b0;
            o_period <= '0;
        end else begin
            if (err_set)        o_err <= 1'b1;
            else if (i_err_clr) o_err <= 1'b0;

            if (rise && (state == MEASURE || state == LOCKED))
                o_period <= per_cnt;

            if (go_idle) begin
                state    <= IDLE;
                good_cnt <= '0;
                o_locked <= 1'b0;
            end else if (state != IDLE && cfg_chg) begin
                state    <= ACQUIRE;
                good_cnt <= '0;
                o_locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (rise) begin
                            state    <= MEASURE;
                            good_cnt <= '0;
                        end
                    end
                    MEASURE: begin
                        if (good) begin
                            good_cnt <= good_cnt + GW'(1);
                            if ((32'(good_cnt) + 32'd1) >= LockCount) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                            end
                        end else if (bad_rise) begin
                            good_cnt <= '0;
                        end else if (stuck) begin
                            state    <= ACQUIRE;
                            good_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (bad_rise) begin
                            state    <= MEASURE;
                            good_cnt <= '0;
                            o_locked <= 1'b0;
                        end else if (stuck) begin
                            state    <= ACQUIRE;
                            good_cnt <= '0;
                            o_locked <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        good_cnt <= '0;
                        o_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sync_clk_div_chk.sv
// Directed bench for sync_clk_div_chk: a cycle-stepped divider model drives i_div_clk and
// expected outputs are queued as stimulus is applied, then popped at the sampling point.
module tb_sync_clk_div_chk;

    logic       i_clk_ref = 1'b0;
    logic       i_rst;
    logic       i_en;
    logic       i_div_clk;
    logic [2:0] i_div_log2;
    logic       i_err_clr;
    logic       o_locked;
    logic       o_err;
    logic [5:0] o_period;

    typedef struct {
        string      tag;
        logic       lk;
        logic       er;
        logic [5:0] per;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   div_hi, div_per, ph;
    bit   force_lo, stuck;

    sync_clk_div_chk #(.MaxLog2(4), .LockCount(4)) dut (
        .i_clk_ref (i_clk_ref),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_div_clk (i_div_clk),
        .i_div_log2(i_div_log2),
        .i_err_clr (i_err_clr),
        .o_locked  (o_locked),
        .o_err     (o_err),
        .o_period  (o_period)
    );

    always #5 i_clk_ref = ~i_clk_ref;

    // Each step waits one edge, then drives the next divider sample 1 ns later.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk_ref);
            #1;
            if (force_lo) begin
                i_div_clk = 1'b0;
            end else if (stuck) begin
                i_div_clk = 1'b1;
            end else begin
                i_div_clk = (ph < div_hi);
                ph = (ph + 1 == div_per) ? 0 : ph + 1;
            end
        end
    endtask

    task automatic restart(input logic [2:0] k, input int hi, input int per);
        i_en       = 1'b0;
        i_div_log2 = k;
        div_hi     = hi;
        div_per    = per;
        force_lo   = 1'b1;
        stuck      = 1'b0;
        step(3);
        i_en = 1'b1;
        step(2);
        ph       = 0;
        force_lo = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic lk, input logic er, input logic [5:0] per);
        sb.push_back('{tag, lk, er, per});
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard: observed empty queue, expected an entry");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (o_locked === e.lk) else begin
                errors++;
                $error("FAIL %s o_locked: observed %0b expected %0b", e.tag, o_locked, e.lk);
            end
            checks++;
            assert (o_err === e.er) else begin
                errors++;
                $error("FAIL %s o_err: observed %0b expected %0b", e.tag, o_err, e.er);
            end
            checks++;
            assert (o_period === e.per) else begin
                errors++;
                $error("FAIL %s o_period: observed %0d expected %0d", e.tag, o_period, e.per);
            end
        end
    endtask

    task automatic pulse_reset();
        #2;
        i_rst = 1'b1;
        #1;
        expect_out("async_reset", 1'b0, 1'b0, 6'd0);
        check_out();
        #4;
        i_rst = 1'b0;
    endtask

    initial begin
        i_rst      = 1'b1;
        i_en       = 1'b0;
        i_div_clk  = 1'b0;
        i_div_log2 = 3'd0;
        i_err_clr  = 1'b0;
        div_hi     = 1;
        div_per    = 2;
        ph         = 0;
        force_lo   = 1'b1;
        stuck      = 1'b0;

        expect_out("reset", 1'b0, 1'b0, 6'd0);
        step(3);
        check_out();
        #2;
        i_rst = 1'b0;

        // Lock at k=2 with a /4 divider: first edge plus four good periods.
        restart(3'd2, 2, 4);
        expect_out("k2_pre_lock", 1'b0, 1'b0, 6'd4);
        step(18);
        check_out();
        expect_out("k2_lock", 1'b1, 1'b0, 6'd4);
        step(1);
        check_out();

        i_en = 1'b0;
        expect_out("disable", 1'b0, 1'b0, 6'd4);
        step(1);
        check_out();

        // Stuck-high clock while locked at k=1, then clear the sticky error.
        restart(3'd1, 1, 2);
        expect_out("k1_pre_lock", 1'b0, 1'b0, 6'd2);
        step(10);
        check_out();
        expect_out("k1_lock", 1'b1, 1'b0, 6'd2);
        step(1);
        check_out();
        stuck = 1'b1;
        expect_out("stuck_last_good", 1'b1, 1'b0, 6'd2);
        step(3);
        check_out();
        expect_out("stuck_err", 1'b0, 1'b1, 6'd2);
        step(1);
        check_out();
        i_err_clr = 1'b1;
        expect_out("err_clr", 1'b0, 1'b0, 6'd2);
        step(1);
        check_out();
        i_err_clr = 1'b0;

        restart(3'd3, 2, 4);
        expect_out("wrong_ratio", 1'b0, 1'b0, 6'd4);
        step(40);
        check_out();

        // Duty error at k=3: one period with high time 3, then relock.
        restart(3'd3, 4, 8);
        expect_out("k3_pre_lock", 1'b0, 1'b0, 6'd8);
        step(34);
        check_out();
        expect_out("k3_lock", 1'b1, 1'b0, 6'd8);
        step(1);
        check_out();
        step(5);
        div_hi = 3;
        step(8);
        div_hi = 4;
        expect_out("duty_before", 1'b1, 1'b0, 6'd8);
        step(2);
        check_out();
        expect_out("duty_err", 1'b0, 1'b1, 6'd8);
        step(1);
        check_out();
        expect_out("relock_pre", 1'b0, 1'b1, 6'd8);
        step(31);
        check_out();
        expect_out("relock", 1'b1, 1'b1, 6'd8);
        step(1);
        check_out();

        pulse_reset();

        restart(3'd2, 2, 4);
        expect_out("cfg_lock", 1'b1, 1'b0, 6'd4);
        step(19);
        check_out();
        i_div_log2 = 3'd1;
        expect_out("cfg_change", 1'b0, 1'b0, 6'd4);
        step(1);
        check_out();
        expect_out("cfg_after", 1'b0, 1'b0, 6'd4);
        step(12);
        check_out();

        // Error event and clear in the same cycle: set wins.
        restart(3'd1, 1, 2);
        expect_out("col_lock", 1'b1, 1'b0, 6'd2);
        step(11);
        check_out();
        stuck = 1'b1;
        expect_out("col_pre", 1'b1, 1'b0, 6'd2);
        step(3);
        check_out();
        i_err_clr = 1'b1;
        expect_out("set_clr_collision", 1'b0, 1'b1, 6'd2);
        step(1);
        check_out();
        i_err_clr = 1'b0;

        pulse_reset();

        restart(3'd0, 2, 4);
        expect_out("illegal_k0", 1'b0, 1'b0, 6'd0);
        step(40);
        check_out();
        restart(3'd5, 2, 4);
        expect_out("illegal_k5", 1'b0, 1'b0, 6'd0);
        step(40);
        check_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_clk_div_chk.md
# sync_clk_div_chk

Divided-clock checker: the receiving end of the synchronous clock divider. It samples one divided-clock output as data in the `i_clk_ref` domain, measures its period and high time, and compares them against the expected 2^k ratio. It asserts a lock flag after consecutive good periods and raises a sticky error on any loss of lock. It sits beside the divider in the clock-generation block and feeds lock/error status to the control registers.

## Interface

**Parameters**
- `MaxLog2`, default 4: largest supported k; maximum ratio is 2^MaxLog2.
- `LockCount`, default 4: number of consecutive good periods required before lock.

**Ports**
- `i_clk_ref`, input, 1: reference clock, the same clock that drives the divider.
- `i_rst`, input, 1: reset, asynchronous and active-high.
- `i_en`, input, 1: checker enable; low forces IDLE.
- `i_div_clk`, input, 1: divided clock under test, sampled as data.
- `i_div_log2`, input, 3: expected k (ratio 2^k). Legal range is 1..MaxLog2.
- `i_err_clr`, input, 1: single-cycle clear of `o_err`.
- `o_locked`, output, 1: ratio locked.
- `o_err`, output, 1: sticky lock-loss error.
- `o_period`, output, MaxLog2+2: last measured period in ref cycles.

Decided: one clock (`i_clk_ref`); reset `i_rst` is asynchronous and active-high.

## Operation

- **Input stage.** `d1` is registered `i_div_clk` and `d2` is registered `d1`. A rising edge is `rise = d1 & ~d2`.
- **Expected values.** `exp_per = 1 << k` and `exp_hi = 1 << (k-1)`. Both are computed at width MaxLog2+2.
- **Period counter `per_cnt`.** Loads 1 on `rise`. Otherwise increments, saturating at all-ones.
- **High counter `hi_cnt`.** Loads 1 on `rise`. Otherwise increments when `d1` is 1.
- **Good period.** `rise` with `per_cnt == exp_per` and `hi_cnt == exp_hi`. Sampled values are taken before the reload.
- **Bad period.** Either of:
  - `rise` where either compare fails;
  - no `rise` while `per_cnt >= exp_per` (stuck or slow clock).
- **`o_period`.** Loads `per_cnt` on every `rise` after the first edge.
- **FSM states:** IDLE, ACQUIRE, MEASURE, LOCKED.
  - IDLE: entered when `i_en` is 0 or k is illegal. Counters and `good_cnt` are cleared. Exit to ACQUIRE when `i_en` is 1 and k is legal.
  - ACQUIRE: the first `rise` moves to MEASURE. No compare is done on this edge.
  - MEASURE:
    - good → `good_cnt++`; reaching LockCount moves to LOCKED;
    - bad on `rise` → `good_cnt = 0`, stay in MEASURE;
    - stuck → ACQUIRE.
  - LOCKED:
    - good → stay;
    - any bad → `o_err` set, `good_cnt = 0`, go to MEASURE (on `rise`) or ACQUIRE (on stuck).
- **Configuration change.** `i_div_log2` is registered each cycle. Any change outside IDLE goes to ACQUIRE and drops lock. `o_err` is not set.
- **`o_err`.** Sticky. Cleared only by `i_err_clr` or reset. If a set and a clear occur in the same cycle, set wins.
- **Disable.** `i_en` falling goes to IDLE and drops `o_locked`. `o_err` is not set.

## Timing

- **Reset values:** `o_locked` = 0, `o_err` = 0, `o_period` = 0, FSM in IDLE, `d1`/`d2`/counters = 0.
- **Edge latency.** `rise` is seen 2 cycles after the `i_div_clk` rising transition.
- **Lock and error latency.** `o_locked` and `o_err` are registered. Each changes the cycle after the deciding `rise` or stuck event.
- **Minimum lock time** from the first seen edge: LockCount × 2^k cycles, plus 1.
- **Mid-operation reset.** Asserting `i_rst` clears all state and outputs immediately, asynchronously.

## Configuration

- **Macro `SYNC_CLK_DIV_CHK_SYNC_EN`.**
  - Defined: two extra flops are inserted before `d1`, giving a 2-flop synchronizer for a divided clock from another domain or a pad. Every latency figure above grows by 2 cycles.
  - Undefined: `i_div_clk` is assumed synchronous to `i_clk_ref` and goes directly to `d1`.

## Test plan

- **Lock at k = 2.** Divider `o_clk[2]` (÷4), k = 2, `i_en` = 1 → `o_locked` = 1 after 4 good periods; `o_period` = 4; `o_err` = 0.
- **Wrong ratio.** Checker k = 3 fed ÷4 → `o_locked` stays 0, `o_err` stays 0, `o_period` = 4.
- **Stuck clock.** Locked at k = 1, then `i_div_clk` held at 1 → `o_locked` = 0 and `o_err` = 1 the cycle after `per_cnt` reaches 2 with no edge. `i_err_clr` then clears `o_err`.
- **Duty error.** Locked at k = 3, inject one period with high time 3, low time 5 → `o_err` = 1 and lock is lost. Relock occurs after 4 further good periods.
- **Config change and set/clear collision.** Locked, change k from 2 to 1 → `o_locked` drops with `o_err` = 0. Separately, an error event in the same cycle as `i_err_clr` → `o_err` = 1.
- **Async reset and illegal k.** `i_rst` pulsed mid-lock (off-edge) → all outputs 0 immediately. k = 0 → FSM stays in IDLE and `o_locked` stays 0.
